// File: rtl/io_pkg.sv
// io_pkg: register offsets, bit indices and interrupt FSM encoding shared by the timer/intc block.
package io_pkg;
  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_LOAD    = 3'd1;
  localparam logic [2:0] A_COUNT   = 3'd2;
  localparam logic [2:0] A_STATUS  = 3'd3;
  localparam logic [2:0] A_SCRATCH = 3'd4;
  localparam int C_TEN  = 0;
  localparam int C_TIRQ = 1;
  localparam int C_EIRQ = 2;
  localparam int C_AUTO = 3;
  localparam int S_TP = 0;
  localparam int S_EP = 1;
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, ACK = 2'b10} state_e;
endpackage

// File: rtl/io_timer_intc_if.sv
// io_timer_intc_if: CPU I/O port bus (strobes, address, write and read data).
interface io_timer_intc_if #(parameter int DW = 32);
  logic          io_cs;
  logic          io_rd;
  logic          io_wr;
  logic [31:0]   Addr;
  logic [DW-1:0] D_IN;
  logic [DW-1:0] D_OUT;
  modport master (output io_cs, io_rd, io_wr, Addr, D_IN, input D_OUT);
  modport slave  (input io_cs, io_rd, io_wr, Addr, D_IN, output D_OUT);
endinterface

// File: rtl/io_timer_intc_timer.sv
// io_timer: programmable down-counter with optional auto-reload and a one-cycle fire pulse.
module io_timer #(parameter int DW = 32) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          auto_reload,
  input  logic          load_we,
  input  logic          count_we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] load_q,
  output logic [DW-1:0] count_q,
  output logic          fire
);
  localparam logic [DW-1:0] ONE = {{(DW-1){1'b0}}, 1'b1};
  logic [DW-1:0] load_d, count_d;
  // a software COUNT write overrides the decrement and suppresses firing
  always_comb begin
    fire    = 1'b0;
    load_d  = load_we ? wdata : load_q;
    count_d = count_q;
    if (count_we) count_d = wdata;
    else if (en && count_q != '0) begin
      fire    = count_q == ONE;
      count_d = fire ? (auto_reload ? load_q : '0) : count_q - ONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      load_q  <= '0;
      count_q <= '0;
    end else begin
      load_q  <= load_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/io_timer_intc.sv
// io_timer_intc: I/O-mapped control/timer/scratch registers plus timer/external interrupt merge with ack handshake.
module io_timer_intc import io_pkg::*; #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  io_timer_intc_if.slave      bus,
  input  logic                ext_irq,
  input  logic                int_ack,
  output logic                intr
);
  logic [3:0]             ctrl_q, ctrl_d;
  logic [DW-1:0]          scratch_q, scratch_d, load_q, count_q, rdata;
  logic                   tp_q, tp_d, ep_q, ep_d, prev_q, prev_d, fire, we, req;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             idx;
  state_e                 state_q, state_d;
  logic                   unused_addr;
  assign unused_addr = ^{bus.Addr[31:5], bus.Addr[1:0]};
  assign idx = bus.Addr[4:2];
  assign we  = bus.io_cs & bus.io_wr;
  assign req = (tp_q & ctrl_q[C_TIRQ]) | (ep_q & ctrl_q[C_EIRQ]);
  io_timer #(.DW(DW)) u_timer (
    .clk(clk), .reset(reset), .en(ctrl_q[C_TEN]), .auto_reload(ctrl_q[C_AUTO]),
    .load_we(we && idx == A_LOAD), .count_we(we && idx == A_COUNT), .wdata(bus.D_IN),
    .load_q(load_q), .count_q(count_q), .fire(fire)
  );
  // hardware set of a pending bit wins over a same-cycle write-1-to-clear
  always_comb begin
    ctrl_d    = (we && idx == A_CTRL) ? bus.D_IN[3:0] : ctrl_q;
    scratch_d = (we && idx == A_SCRATCH) ? bus.D_IN : scratch_q;
    sync_d    = {sync_q[SYNC_STAGES-2:0], ext_irq};
    prev_d    = sync_q[SYNC_STAGES-1];
    tp_d      = fire | (tp_q & ~(we && idx == A_STATUS && bus.D_IN[S_TP]));
    ep_d      = (sync_q[SYNC_STAGES-1] & ~prev_q) | (ep_q & ~(we && idx == A_STATUS && bus.D_IN[S_EP]));
  end
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = req ? REQ : IDLE;
      REQ:     state_d = int_ack ? ACK : (req ? REQ : IDLE);
      ACK:     state_d = (!int_ack && !req) ? IDLE : ACK;
      default: state_d = IDLE;
    endcase
  end
  assign intr = state_q == REQ;
  always_comb begin
    rdata = '0;
    case (idx)
      A_CTRL:    rdata = {{(DW-4){1'b0}}, ctrl_q};
      A_LOAD:    rdata = load_q;
      A_COUNT:   rdata = count_q;
      A_STATUS:  rdata = {{(DW-2){1'b0}}, ep_q, tp_q};
      A_SCRATCH: rdata = scratch_q;
      default:   rdata = '0;
    endcase
  end
  assign bus.D_OUT = (bus.io_cs && bus.io_rd) ? rdata : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      scratch_q <= '0;
      sync_q    <= '0;
      prev_q    <= 1'b0;
      tp_q      <= 1'b0;
      ep_q      <= 1'b0;
      state_q   <= IDLE;
    end else begin
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      sync_q    <= sync_d;
      prev_q    <= prev_d;
      tp_q      <= tp_d;
      ep_q      <= ep_d;
      state_q   <= state_d;
    end
  end
endmodule

// File: doc/io_timer_intc.md
Name: io_timer_intc

Overview:
Memory-mapped I/O slave on the CPU's I/O port. It decodes io_cs/io_rd/io_wr plus the low address bits, and holds a control register, a programmable down-counter timer and a scratch register. It returns read data on the CPU's I/O data-in bus. It also merges timer and external interrupt sources into a single intr request, handshaked against the MCU's int_ack.

Parameters:
DW, 32, data width of register bus.
SYNC_STAGES, 2, flops in ext_irq synchronizer (≥2).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
io_cs  in  1  I/O chip select from CPU
io_rd  in  1  I/O read strobe
io_wr  in  1  I/O write strobe
Addr  in  32  CPU ALU_OUT address; only Addr[4:2] decoded
D_IN  in  DW  write data (CPU D_OUT)
D_OUT  out  DW  read data (to CPU D_IOToInt)
ext_irq  in  1  asynchronous external interrupt source, level
intr  out  1  interrupt request to MCU
int_ack  in  1  interrupt acknowledge from MCU

Behaviour:
- Clocking: one clock (clk). Reset is synchronous and active-high (reset); all state clears on the clk edge where reset=1.
- Reset values: all registers 0; FSM in IDLE; intr=0. D_OUT=0 while reset is held, because it is combinational from cleared registers.
- Register map (byte offsets, Addr[4:2]):
  - 0x00 CTRL: [0] timer_en, [1] tirq_en, [2] eirq_en, [3] auto_reload; other bits read 0.
  - 0x04 LOAD: reload value.
  - 0x08 COUNT: read current count; a write loads count.
  - 0x0C STATUS: [0] t_pend, [1] e_pend. Write-1-to-clear.
  - 0x10 SCRATCH: 32-bit read/write.
  - 0x14–0x1C: reads 0, writes ignored.
- Read: combinational, zero latency. D_OUT = selected register when io_cs&io_rd, else 0 (never Z; the CPU muxes it).
- Write: on the clk edge when io_cs&io_wr. io_rd&io_wr together: the write still occurs and the read returns the pre-write value.
- Timer, each clk:
  - If a COUNT write is active, count←D_IN. Software wins over decrement.
  - Else if timer_en and count≠0: if count==1, set t_pend and count←(auto_reload ? LOAD : 0); else count←count−1.
  - Period with auto_reload = LOAD cycles. LOAD=0 with auto_reload: count stops at 0 and never fires.
- ext_irq path: SYNC_STAGES-flop synchronizer, then a prior-value flop. Rising edge (sync & ~prev) sets e_pend. With SYNC_STAGES=2, e_pend is visible 3 edges after ext_irq rises. Level-held ext_irq sets e_pend once only.
- Set/clear collision: the same cycle's hardware set beats a STATUS write-1-clear.
- Pending bits set regardless of the enables; the enables gate only the interrupt request. req = (t_pend&tirq_en)|(e_pend&eirq_en).
- Interrupt FSM (registered; intr=1 only in REQ):
  - IDLE→REQ when req=1.
  - REQ→ACK when int_ack=1; intr drops the same edge.
  - ACK→IDLE when int_ack=0 and req=0. Software must clear the pending bits, which prevents re-request while the ISR runs.
  - ACK with int_ack=0 and req still 1: stays in ACK.
  - REQ with req falling before ack (software cleared/disabled): REQ→IDLE.
- Reset mid-handshake: returns to IDLE with intr=0. Pending and count are lost.
- Latency: req to intr = 1 clk.

Decomposition:
- Shared package io_pkg holds:
  - register offsets (CTRL/LOAD/COUNT/STATUS/SCRATCH);
  - CTRL and STATUS bit indices;
  - FSM state encoding IDLE=2'b00, REQ=2'b01, ACK=2'b10.
- Sub-module io_timer holds count, LOAD, the reload/decrement logic and the t_pend set pulse output.
- Synchronizer, decode and FSM stay in the top.

Test Plan:
- Reset: assert reset 2 clks with ext_irq=0 → all reads return 0, intr=0. Write SCRATCH=0xDEADBEEF then read it → 0xDEADBEEF. Read 0x18 → 0.
- One-shot timer: LOAD=5, COUNT=5, CTRL=0x3 → t_pend=1 at the 5th edge after the CTRL write, intr=1 one edge later, then COUNT=0 stays.
- Auto-reload: LOAD=4, COUNT=4, CTRL=0xB, with STATUS cleared by W1C each time → t_pend re-sets every 4 clks and COUNT reads 4,3,2,1,4….
- Handshake: raise int_ack while intr=1 → intr=0 next edge. Drop int_ack without clearing STATUS → intr stays 0 (ACK). Then write STATUS=0x1 → FSM IDLE; intr remains 0.
- External edge: CTRL=0x4, pulse ext_irq high 10 clks → e_pend=1 after 3 edges, intr after 4, exactly one assertion. Write STATUS=0x2 on the same edge the timer fires → t_pend=1, e_pend=0.
- Collision: write COUNT=9 on the cycle count==1 with timer_en → COUNT=9 and t_pend not set.
